keccak_squeeze: RTL

- Output-side reader of the 1600-bit Keccak state. It is the consumer end of the state bus that the permutation rounds write.
- It captures a permuted state and streams its rate lanes as 64-bit words over a valid/ready interface.
- It requests further permutations until the programmed number of lanes has been emitted.
- It serves SHAKE128/SHAKE256 XOF output and SHA3-256/512 digests in the Kyber datapath.

---
 rtl/keccak_pkg.sv | 43 ++++
 rtl/keccak_squeeze.sv | 134 +++++++++++++
 2 files changed

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keccak_pkg
// Brief    : Shared Keccak definitions: lane/state geometry, rate-mode
//            encoding, rate lookup and lane extraction helpers.
// Revision : 1.0 - initial release
// ============================================================================
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int STATE_W   = LANE_W * NUM_LANES;

  // Rate select as driven on the mode input
  typedef enum logic [1:0] {
    SHAKE128 = 2'd0,
    SHAKE256 = 2'd1,
    SHA3_256 = 2'd2,
    SHA3_512 = 2'd3
  } mode_e;

  // Number of rate lanes per permutation for each mode
  function automatic logic [4:0] rate_lanes(input mode_e m);
    logic [4:0] r;
    r = 5'd9;
    case (m)
      SHAKE128: r = 5'd21;
      SHAKE256: r = 5'd17;
      SHA3_256: r = 5'd17;
      SHA3_512: r = 5'd9;
      default:  r = 5'd9;
    endcase
    return r;
  endfunction

  // Lane i = x + 5*y of a flat state vector
  function automatic logic [LANE_W-1:0] lane(input logic [STATE_W-1:0] s,
                                             input logic [4:0]         i);
    return s[32'(i) * LANE_W +: LANE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_squeeze.sv
`default_nettype none
// ============================================================================
// Module   : keccak_squeeze
// Brief    : Captures a permuted Keccak state and streams its rate lanes as
//            64-bit words over valid/ready, requesting further permutations
//            until the programmed number of lanes has been emitted.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_squeeze
  import keccak_pkg::mode_e;
  import keccak_pkg::rate_lanes;
#(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [LEN_W-1:0]            len_lanes_i,
  input  logic [LANE_W*NUM_LANES-1:0] state_in_i,
  input  logic                        state_valid_i,
  output logic                        state_ready_o,
  output logic                        perm_req_o,
  output logic [LANE_W-1:0]           dout_o,
  output logic                        dout_valid_o,
  input  logic                        dout_ready_i,
  output logic                        dout_last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int SW = LANE_W * NUM_LANES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } fsm_e;

  fsm_e              state_q;
  logic [4:0]        rate_q;
  logic [4:0]        idx_q;
  logic [LEN_W-1:0]  rem_q;
  logic [SW-1:0]     buf_q;
  logic [LANE_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              dout_last_q;
  logic              perm_req_q;
  logic              done_q;

  logic [4:0]        idx_nxt;
  logic [LEN_W-1:0]  rate_ext;

  assign idx_nxt  = idx_q + 5'd1;
  assign rate_ext = LEN_W'(rate_q);

  // Control FSM: latches the request, captures the state, walks the rate lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rate_q       <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      perm_req_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      perm_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && (len_lanes_i != '0)) begin
            rate_q  <= rate_lanes(mode_e'(mode_i));
            rem_q   <= len_lanes_i;
            idx_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (state_valid_i) begin
            buf_q        <= state_in_i;
            idx_q        <= '0;
            dout_q       <= state_in_i[LANE_W-1:0];
            dout_valid_q <= 1'b1;
            dout_last_q  <= (rem_q == LEN_W'(1));
            // Ask upstream to permute again while this block drains
            perm_req_q   <= (rem_q > rate_ext);
            state_q      <= STREAM;
          end
        end
        STREAM: begin
          if (dout_ready_i) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              idx_q        <= '0;
              dout_q       <= '0;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= IDLE;
            end else if (idx_q == (rate_q - 5'd1)) begin
              // Rate block exhausted; wait for the next permuted state
              idx_q        <= '0;
              dout_q       <= '0;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              state_q      <= LOAD;
            end else begin
              idx_q       <= idx_nxt;
              dout_q      <= buf_q[32'(idx_nxt) * LANE_W +: LANE_W];
              dout_last_q <= (rem_q == LEN_W'(2));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_ready_o = (state_q == LOAD);
  assign busy_o        = (state_q != IDLE);
  assign perm_req_o    = perm_req_q;
  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign dout_last_o   = dout_last_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire
